// File: rtl/tempsens_sar_ctrl_if.sv
// Bundle of the control and sensor signals of tempsens_sar_ctrl.
//   master : host/sensor side. Drives start/continuous/abort/settle and the
//            sensor's temp-delay line, and observes the controller outputs.
//   slave  : the SAR controller itself.
// Signals:
//   i_start, i_continuous, i_abort : conversion control
//   i_settle      : extra MEASURE cycles per bit trial
//   i_temp_delay  : sensor comparator output (asynchronous to clk)
//   o_dac_data, o_dac_en, o_precharge_n : sensor drive
//   o_busy, o_valid, o_result : status and result
interface tempsens_sar_ctrl_if #(
  parameter int N_VDAC   = 7,
  parameter int N_SETTLE = 4
);
  logic                i_start;
  logic                i_continuous;
  logic                i_abort;
  logic [N_SETTLE-1:0] i_settle;
  logic                i_temp_delay;
  logic [N_VDAC-1:0]   o_dac_data;
  logic                o_dac_en;
  logic                o_precharge_n;
  logic                o_busy;
  logic                o_valid;
  logic [N_VDAC-1:0]   o_result;

  modport master (
    output i_start, i_continuous, i_abort, i_settle, i_temp_delay,
    input  o_dac_data, o_dac_en, o_precharge_n, o_busy, o_valid, o_result
  );

  modport slave (
    input  i_start, i_continuous, i_abort, i_settle, i_temp_delay,
    output o_dac_data, o_dac_en, o_precharge_n, o_busy, o_valid, o_result
  );
endinterface

// File: rtl/tempsens_sar_ctrl.sv
// Successive-approximation controller for a delay-based temperature sensor.
// Each bit trial runs PRECHARGE -> TRANSITION -> MEASURE (settle+3 cycles)
// -> EVAL, MSB first. After bit 0 the result is published in DONE with a
// one-cycle o_valid.
// Ports:
//   clk    : single clock, all state changes on its rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : tempsens_sar_ctrl_if.slave (control inputs, sensor drive,
//            busy/valid/result outputs)
module tempsens_sar_ctrl #(
  parameter int N_VDAC   = 7,
  parameter int N_SETTLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tempsens_sar_ctrl_if.slave    bus
);

  localparam int BW = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;
  localparam int CW = N_SETTLE + 1;
  localparam logic [N_VDAC-1:0] ONES = {N_VDAC{1'b1}};
  localparam logic [N_VDAC-1:0] ONE  = N_VDAC'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRECHARGE  = 3'd1,
    ST_TRANSITION = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_EVAL       = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [BW-1:0]       bit_r, bit_s;
  logic [N_VDAC-1:0]   code_r, code_s;
  logic [N_SETTLE-1:0] settle_r, settle_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [N_VDAC-1:0]   result_r, result_s;
  logic                meta_r, sync_r;
  logic [N_VDAC-1:0]   trial_s;
  logic [N_VDAC-1:0]   dac_data_s;
  logic                dac_en_s, precharge_n_s, valid_s;

  // Two-flop synchronizer for the asynchronous sensor output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= bus.i_temp_delay;
      sync_r <= meta_r;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      bit_r    <= '0;
      code_r   <= '0;
      settle_r <= '0;
      cnt_r    <= '0;
      result_r <= '0;
    end else begin
      state_r  <= state_s;
      bit_r    <= bit_s;
      code_r   <= code_s;
      settle_r <= settle_s;
      cnt_r    <= cnt_s;
      result_r <= result_s;
    end
  end

  // Next-state, datapath update and state-decoded sensor outputs.
  always_comb begin
    state_s       = state_r;
    bit_s         = bit_r;
    code_s        = code_r;
    settle_s      = settle_r;
    cnt_s         = cnt_r;
    result_s      = result_r;
    dac_en_s      = 1'b0;
    dac_data_s    = ONES;
    precharge_n_s = 1'b0;
    valid_s       = 1'b0;
    // code_r only holds committed bits above bit_r, so OR-ing in the
    // current bit yields the trial code with all lower bits zero.
    trial_s       = code_r | (ONE << bit_r);

    case (state_r)
      ST_IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          state_s  = ST_PRECHARGE;
          bit_s    = BW'(N_VDAC - 1);
          code_s   = '0;
          settle_s = bus.i_settle;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_PRECHARGE: begin
        dac_en_s = 1'b1;
        state_s  = ST_TRANSITION;
      end
      ST_TRANSITION: begin
        dac_en_s      = 1'b1;
        dac_data_s    = '0;
        precharge_n_s = 1'b1;
        cnt_s         = '0;
        state_s       = ST_MEASURE;
      end
      ST_MEASURE: begin
        dac_en_s      = 1'b1;
        dac_data_s    = trial_s;
        precharge_n_s = 1'b1;
        // settle+3 cycles: count 0 .. settle+2
        if (cnt_r == ({1'b0, settle_r} + CW'(2))) begin
          state_s = ST_EVAL;
        end else begin
          cnt_s   = cnt_r + CW'(1);
        end
      end
      ST_EVAL: begin
        dac_en_s      = 1'b1;
        dac_data_s    = trial_s;
        precharge_n_s = 1'b1;
        // Clearing the trial bit leaves exactly code_r.
        code_s        = sync_r ? trial_s : code_r;
        if (bit_r == BW'(0)) begin
          result_s = sync_r ? trial_s : code_r;
          state_s  = ST_DONE;
        end else begin
          bit_s    = bit_r - BW'(1);
          state_s  = ST_PRECHARGE;
        end
      end
      ST_DONE: begin
        dac_en_s = 1'b1;
        valid_s  = 1'b1;
        if (bus.i_continuous) begin
          state_s  = ST_PRECHARGE;
          bit_s    = BW'(N_VDAC - 1);
          code_s   = '0;
          settle_s = bus.i_settle;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Abort wins over everything and must not publish a result.
    if ((state_r != ST_IDLE) && bus.i_abort) begin
      state_s  = ST_IDLE;
      result_s = result_r;
    end else begin
      state_s  = state_s;
    end
  end

  assign bus.o_dac_data    = dac_data_s;
  assign bus.o_dac_en      = dac_en_s;
  assign bus.o_precharge_n = precharge_n_s;
  assign bus.o_valid       = valid_s;
  assign bus.o_busy        = (state_r != ST_IDLE);
  assign bus.o_result      = result_r;

endmodule

// File: tb/tb_tempsens_sar_ctrl.sv
// Self-checking bench for tempsens_sar_ctrl with a threshold sensor model:
// the sensor reports delay=1 when the DAC code is at or below thr while the
// precharge is released.
module tb_tempsens_sar_ctrl;
  localparam int N  = 7;
  localparam int NS = 4;

  logic clk;
  logic rst_n;
  int   thr;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_result;

  int         obs_cycles;
  int         obs_ntrial;
  bit         obs_timeout;
  logic [N-1:0] obs_result;
  logic [N-1:0] obs_trial [0:N-1];

  tempsens_sar_ctrl_if #(.N_VDAC(N), .N_SETTLE(NS)) bus ();

  tempsens_sar_ctrl #(.N_VDAC(N), .N_SETTLE(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.i_temp_delay = bus.o_precharge_n && (int'(bus.o_dac_data) <= thr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: SAR converges to the largest code not above thr.
  function automatic int model_result(input int t);
    if (t < 0) return 0;
    if (t > (1 << N) - 1) return (1 << N) - 1;
    return t;
  endfunction

  // k-th trial code of a binary search against thr.
  function automatic int model_trial(input int t, input int k);
    int code = 0;
    for (int i = 0; i < k; i++) begin
      if (code + (1 << (N - 1 - i)) <= t) code = code + (1 << (N - 1 - i));
    end
    return code + (1 << (N - 1 - k));
  endfunction

  function automatic int model_cycles(input int s);
    return N * (s + 6) + 1;
  endfunction

  // Issue one start pulse and observe until o_valid (observation only).
  task automatic do_conv(input int s0, input int s1);
    logic [N-1:0] prev;
    int sv0, sv1;
    sv0 = s0; sv1 = s1;
    @(negedge clk);
    bus.i_settle = sv0[NS-1:0];
    bus.i_start  = 1'b1;
    obs_cycles = 0; obs_ntrial = 0; obs_timeout = 1'b1; prev = '1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      obs_cycles++;
      if (obs_cycles == 1) begin
        bus.i_start  = 1'b0;
        bus.i_settle = sv1[NS-1:0];
      end
      if (bus.o_precharge_n && bus.o_dac_data != '0 && prev == '0 && obs_ntrial < N) begin
        obs_trial[obs_ntrial] = bus.o_dac_data;
        obs_ntrial++;
      end
      prev = bus.o_dac_data;
      if (bus.o_valid) begin
        obs_timeout = 1'b0;
        obs_result  = bus.o_result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_continuous = 1'b0; bus.i_abort = 1'b0;
    bus.i_settle = '0; thr = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_result !== 7'd0) begin n_fail++; $display("FAIL reset_result: got %0d want 0", bus.o_result); end
    n_cmp++; if (bus.o_dac_en !== 1'b0) begin n_fail++; $display("FAIL reset_dac_en: got %0b want 0", bus.o_dac_en); end
    n_cmp++; if (bus.o_dac_data !== 7'd127) begin n_fail++; $display("FAIL reset_dac_data: got %0d want 127", bus.o_dac_data); end
    n_cmp++; if (bus.o_precharge_n !== 1'b0) begin n_fail++; $display("FAIL reset_precharge_n: got %0b want 0", bus.o_precharge_n); end
    rst_n = 1'b1;
    exp_result = 0;
    // i_continuous alone must not start a conversion
    bus.i_continuous = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_continuous_only: busy got %0b want 0", bus.o_busy); end
    bus.i_continuous = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    thr = 77;
    do_conv(0, 0);
    n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL basic_timeout: no o_valid within budget"); end
    n_cmp++; if (int'(obs_result) !== model_result(thr)) begin n_fail++; $display("FAIL basic_result: got %0d want %0d", obs_result, model_result(thr)); end
    n_cmp++; if (obs_cycles !== model_cycles(0)) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", obs_cycles, model_cycles(0)); end
    n_cmp++; if (obs_ntrial !== N) begin n_fail++; $display("FAIL basic_ntrial: got %0d want %0d", obs_ntrial, N); end
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (int'(obs_trial[k]) !== model_trial(thr, k)) begin n_fail++; $display("FAIL basic_trial%0d: got %0d want %0d", k, obs_trial[k], model_trial(thr, k)); end
    end
    exp_result = model_result(thr);
    @(negedge clk);
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_width: got %0b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_back_idle: busy got %0b want 0", bus.o_busy); end
  endtask

  task automatic test_boundaries();
    int tv [3];
    int sv [3];
    tv[0] = 0; tv[1] = 127; tv[2] = int'($urandom_range(0, 127));
    sv[0] = 0; sv[1] = 0;   sv[2] = 15;
    for (int i = 0; i < 3; i++) begin
      thr = tv[i];
      do_conv(sv[i], sv[i]);
      n_cmp++; if (obs_timeout || int'(obs_result) !== model_result(thr)) begin n_fail++; $display("FAIL bound_result thr=%0d: got %0d want %0d", thr, obs_result, model_result(thr)); end
      n_cmp++; if (obs_cycles !== model_cycles(sv[i])) begin n_fail++; $display("FAIL bound_latency s=%0d: got %0d want %0d", sv[i], obs_cycles, model_cycles(sv[i])); end
      exp_result = model_result(thr);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int s0, s1;
    for (int i = 0; i < 8; i++) begin
      thr = int'($urandom_range(0, 127));
      s0  = int'($urandom_range(0, 15));
      s1  = (s0 + 1 + int'($urandom_range(0, 14))) % 16;
      do_conv(s0, s1);
      n_cmp++; if (obs_timeout || int'(obs_result) !== model_result(thr)) begin n_fail++; $display("FAIL rand_result thr=%0d: got %0d want %0d", thr, obs_result, model_result(thr)); end
      n_cmp++; if (obs_cycles !== model_cycles(s0)) begin n_fail++; $display("FAIL rand_latency s0=%0d s1=%0d: got %0d want %0d", s0, s1, obs_cycles, model_cycles(s0)); end
      exp_result = model_result(thr);
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    logic [N-1:0] prev;
    int nt, nvalid;
    bit hit;
    thr = int'($urandom_range(0, 127));
    @(negedge clk);
    bus.i_settle = 4'd0; bus.i_start = 1'b1;
    prev = '1; nt = 0; nvalid = 0; hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) bus.i_start = 1'b0;
      if (bus.o_precharge_n && bus.o_dac_data != '0 && prev == '0) nt++;
      prev = bus.o_dac_data;
      if (bus.o_valid) nvalid++;
      if (nt == 3) begin
        bus.i_abort = 1'b1;
        hit = 1'b1;
        break;
      end
    end
    n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL abort_reach_measure: got %0b want 1", hit); end
    @(negedge clk);
    bus.i_abort = 1'b0;
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %0b want 0", bus.o_valid); end
    n_cmp++; if (int'(bus.o_result) !== exp_result) begin n_fail++; $display("FAIL abort_result_kept: got %0d want %0d", bus.o_result, exp_result); end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.o_valid) nvalid++;
    end
    n_cmp++; if (nvalid !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses want 0", nvalid); end
  endtask

  task automatic test_async_reset();
    int nvalid;
    thr = int'($urandom_range(0, 127));
    @(negedge clk);
    bus.i_settle = 4'd0; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (5) @(negedge clk);   // now in EVAL of the MSB
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %0b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %0b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_result !== 7'd0) begin n_fail++; $display("FAIL areset_result: got %0d want 0", bus.o_result); end
    n_cmp++; if (bus.o_dac_en !== 1'b0) begin n_fail++; $display("FAIL areset_dac_en: got %0b want 0", bus.o_dac_en); end
    n_cmp++; if (bus.o_dac_data !== 7'd127) begin n_fail++; $display("FAIL areset_dac_data: got %0d want 127", bus.o_dac_data); end
    n_cmp++; if (bus.o_precharge_n !== 1'b0) begin n_fail++; $display("FAIL areset_precharge_n: got %0b want 0", bus.o_precharge_n); end
    exp_result = 0;
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.o_valid) nvalid++;
    end
    n_cmp++; if (nvalid !== 0 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL areset_quiet: valid pulses %0d busy %0b want 0 0", nvalid, bus.o_busy); end
    thr = int'($urandom_range(0, 127));
    do_conv(1, 1);
    n_cmp++; if (obs_timeout || int'(obs_result) !== model_result(thr)) begin n_fail++; $display("FAIL areset_after_result: got %0d want %0d", obs_result, model_result(thr)); end
    exp_result = model_result(thr);
    @(negedge clk);
  endtask

  task automatic test_continuous();
    int cnt;
    bit got;
    thr = 40;
    bus.i_continuous = 1'b1;
    do_conv(0, 0);
    n_cmp++; if (obs_timeout || int'(obs_result) !== 40) begin n_fail++; $display("FAIL cont_first_result: got %0d want 40", obs_result); end
    thr = 100;
    cnt = 0; got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      cnt++;
      if (bus.o_valid) begin got = 1'b1; break; end
    end
    n_cmp++; if (!got || cnt !== N * 6 + 1) begin n_fail++; $display("FAIL cont_spacing: got %0d cycles want %0d", cnt, N * 6 + 1); end
    n_cmp++; if (int'(bus.o_result) !== model_result(100)) begin n_fail++; $display("FAIL cont_second_result: got %0d want %0d", bus.o_result, model_result(100)); end
    exp_result = model_result(100);
    bus.i_continuous = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL cont_stop: busy got %0b want 0", bus.o_busy); end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    bit clr;
    thr = int'($urandom_range(0, 127));
    @(negedge clk);
    bus.i_settle = 4'd1; bus.i_start = 1'b1;
    nvalid = 0; clr = 1'b0;
    for (int c = 1; c <= model_cycles(1) + 80; c++) begin
      @(negedge clk);
      if (c == 1) bus.i_start = 1'b0;
      else if (c == 4) bus.i_start = 1'b1;      // MEASURE of MSB
      else if (c == 5) bus.i_start = 1'b0;
      if (clr) begin bus.i_start = 1'b0; clr = 1'b0; end
      if (bus.o_valid) begin
        nvalid++;
        if (nvalid == 1) begin
          n_cmp++; if (int'(bus.o_result) !== model_result(thr)) begin n_fail++; $display("FAIL b2b_result: got %0d want %0d", bus.o_result, model_result(thr)); end
        end
        bus.i_start = 1'b1;                      // during DONE
        clr = 1'b1;
      end
    end
    n_cmp++; if (nvalid !== 1) begin n_fail++; $display("FAIL b2b_valid_count: got %0d want 1", nvalid); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy got %0b want 0", bus.o_busy); end
    exp_result = model_result(thr);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_random();
    test_abort();
    test_async_reset();
    test_continuous();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
